// File: rtl/hazard_controller.sv
// =============================================================================
// Module      : hazard_controller
// Description : 5-stage pipeline hazard sequencer: EX/MEM/WB destination
//               scoreboard, fetch/decode stall + flush control, EX forwarding.
//               Optional feature macro: FORWARDING_EN.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module hazard_controller #(
    parameter int REG_ADDR_W   = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_is_load,
    input  logic                   ex_br_taken,
    output logic                   pc_stall,
    output logic                   ifid_stall,
    output logic                   id_flush,
    output logic                   ifid_flush,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  use1;
        logic                  use2;
    } slot_t;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] c_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    slot_t                   r_ex;
    slot_t                   r_mem;
    slot_t                   r_wb;
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [2:0]              r_cnt;
    logic [2:0]              w_cnt_nxt;
    logic [STALL_CNT_W-1:0]  r_stall_cnt;
    logic                    w_flush;
    logic                    w_cond;
    logic                    w_stall;
    logic [1:0]              w_fwd_a;
    logic [1:0]              w_fwd_b;
    slot_t                   w_id_slot;

    function automatic logic f_match(input slot_t s, input logic [REG_ADDR_W-1:0] r);
        return s.valid & s.reg_write & (s.rd == r);
    endfunction

    function automatic logic f_hazard(input slot_t s);
        return (id_use_rs1 & f_match(s, id_rs1)) | (id_use_rs2 & f_match(s, id_rs2));
    endfunction

    // MEM result of a load is not yet available, so only WB may supply it
    function automatic logic [1:0] f_fwd(input logic use_r, input logic [REG_ADDR_W-1:0] rs);
        if (use_r & f_match(r_mem, rs) & ~r_mem.is_load)
            return 2'b01;
        else if (use_r & f_match(r_wb, rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_id_slot.valid     = 1'b1;
        w_id_slot.rd        = id_rd;
        w_id_slot.reg_write = id_reg_write;
        w_id_slot.is_load   = id_is_load;
        w_id_slot.rs1       = id_rs1;
        w_id_slot.rs2       = id_rs2;
        w_id_slot.use1      = id_use_rs1;
        w_id_slot.use2      = id_use_rs2;
    end

    // Branch flush sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_flush     = 1'b0;
        case (r_state)
            S_RUN: begin
                if (ex_br_taken) begin
                    w_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt = S_FLUSH;
                        w_cnt_nxt   = c_FLUSH_RELOAD;
                    end
                end
            end
            S_FLUSH: begin
                w_flush = 1'b1;
                if (ex_br_taken) begin
                    w_cnt_nxt = c_FLUSH_RELOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                    if (r_cnt == 3'd1)
                        w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

`ifdef FORWARDING_EN
    always_comb begin
        w_cond  = f_hazard(r_ex) & r_ex.is_load;
        w_fwd_a = f_fwd(r_ex.use1, r_ex.rs1);
        w_fwd_b = f_fwd(r_ex.use2, r_ex.rs2);
    end
`else
    // ID register reads cannot see a same-cycle WB write, so WB also blocks
    always_comb begin
        w_cond  = f_hazard(r_ex) | f_hazard(r_mem) | f_hazard(r_wb);
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
    end
`endif

    assign w_stall = id_valid & ~w_flush & w_cond;

    // Reset forces every control low in the same cycle it is asserted
    always_comb begin
        pc_stall   = w_stall & ~reset;
        ifid_stall = w_stall & ~reset;
        id_flush   = (w_stall | w_flush) & ~reset;
        ifid_flush = w_flush & ~reset;
        fwd_a      = reset ? 2'b00 : w_fwd_a;
        fwd_b      = reset ? 2'b00 : w_fwd_b;
        stall_cnt  = r_stall_cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_state     <= S_RUN;
            r_cnt       <= 3'd0;
            r_stall_cnt <= '0;
        end else begin
            r_wb    <= r_mem;
            r_mem   <= r_ex;
            r_ex    <= (id_valid & ~w_stall & ~w_flush) ? w_id_slot : '0;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// =============================================================================
// Module      : tb_hazard_controller
// Description : Directed scoreboard bench for hazard_controller (FLUSH_CYCLES=2),
//               second instance with a 4-bit stall counter for saturation.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module tb_hazard_controller;

    typedef struct packed {
        logic       v;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       u1;
        logic       u2;
        logic       rw;
        logic       ld;
    } instr_t;

    typedef struct {
        string       name;
        logic [35:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [2:0]  id_rs1 = '0;
    logic [2:0]  id_rs2 = '0;
    logic        id_use_rs1 = 1'b0;
    logic        id_use_rs2 = 1'b0;
    logic [2:0]  id_rd = '0;
    logic        id_reg_write = 1'b0;
    logic        id_is_load = 1'b0;
    logic        ex_br_taken = 1'b0;

    logic        pc_stall, ifid_stall, id_flush, ifid_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic        s_pc_stall, s_ifid_stall, s_id_flush, s_ifid_flush;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [3:0]  s_stall_cnt;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_controller #(.REG_ADDR_W(3), .FLUSH_CYCLES(2), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .id_flush(id_flush),
        .ifid_flush(ifid_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    hazard_controller #(.REG_ADDR_W(3), .FLUSH_CYCLES(2), .STALL_CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
        .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall), .id_flush(s_id_flush),
        .ifid_flush(s_ifid_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt)
    );

    function automatic instr_t ins(input logic v, input logic [2:0] rd, input logic [2:0] rs1,
                                   input logic [2:0] rs2, input logic u1, input logic u2,
                                   input logic rw, input logic ld);
        instr_t i;
        i.v = v; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        i.u1 = u1; i.u2 = u2; i.rw = rw; i.ld = ld;
        return i;
    endfunction

    instr_t NOP, LD_R3, ADD_R4, LD_R2, ADD_R5, ADD_R1, SUB_R6, LD_R1, ADD_R7, LD_SELF;

    // Drive one cycle of inputs and queue the response expected at mid-cycle
    task automatic step(input string nm, input instr_t i, input logic br, input logic rst,
                        input logic st, input logic fl, input logic [1:0] fa, input logic [1:0] fb);
        exp_t       e;
        logic [7:0] ctl;
        logic [15:0] c16;
        logic [3:0] c4;
        @(posedge clk);
        #1;
        reset        = rst;
        id_valid     = i.v;
        id_rd        = i.rd;
        id_rs1       = i.rs1;
        id_rs2       = i.rs2;
        id_use_rs1   = i.u1;
        id_use_rs2   = i.u2;
        id_reg_write = i.rw;
        id_is_load   = i.ld;
        ex_br_taken  = br;
        if (rst) begin
            exp_cnt = 0;
            ctl     = 8'h00;
        end else begin
            ctl = {st, st, st | fl, fl, fa, fb};
        end
        c16    = (exp_cnt > 65535) ? 16'hFFFF : exp_cnt[15:0];
        c4     = (exp_cnt > 15) ? 4'hF : exp_cnt[3:0];
        e.name = nm;
        e.exp  = {ctl, ctl, c16, c4};
        q.push_back(e);
        if (!rst && st)
            exp_cnt++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step("idle", NOP, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    // Monitor: compare every queued expectation at the falling edge
    initial begin
        exp_t        e;
        logic [35:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {pc_stall, ifid_stall, id_flush, ifid_flush, fwd_a, fwd_b,
                       s_pc_stall, s_ifid_stall, s_id_flush, s_ifid_flush, s_fwd_a, s_fwd_b,
                       stall_cnt, s_stall_cnt};
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (ctl,ctl_small,cnt16,cnt4)",
                             e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        NOP     = '0;
        LD_R3   = ins(1'b1, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        ADD_R4  = ins(1'b1, 3'd4, 3'd3, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        LD_R2   = ins(1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        ADD_R5  = ins(1'b1, 3'd5, 3'd2, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        ADD_R1  = ins(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        SUB_R6  = ins(1'b1, 3'd6, 3'd1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        LD_R1   = ins(1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        ADD_R7  = ins(1'b1, 3'd7, 3'd1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        LD_SELF = ins(1'b1, 3'd1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);

        step("rst0", NOP, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        step("rst1", ADD_R4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);

        // Reset while a load-use stall is active
        step("t1_ld",    LD_R3,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t1_stall", ADD_R4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        step("t1_rst",   ADD_R4, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t1_post",  ADD_R4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        idle(4);

`ifdef FORWARDING_EN
        step("t2_ld",    LD_R2,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t2_stall", ADD_R5, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        step("t2_go",    ADD_R5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t2_fwd",   NOP,    1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
        idle(3);
        step("t3_add",   ADD_R1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t3_sub",   SUB_R6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t3_fwd",   NOP,    1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
        idle(3);
`else
        step("t2_ld",     LD_R2,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t2_st_ex",  ADD_R5, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        step("t2_st_mem", ADD_R5, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        step("t2_st_wb",  ADD_R5, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        step("t2_go",     ADD_R5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        idle(4);
        step("t4_add",    ADD_R1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t4_st_ex",  SUB_R6, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        step("t4_st_mem", SUB_R6, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        step("t4_st_wb",  SUB_R6, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        step("t4_go",     SUB_R6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        idle(4);
`endif

        // Branch taken while ID would stall: flush wins for FLUSH_CYCLES=2
        step("t5_ld",   LD_R1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t5_br",   ADD_R7, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        step("t5_fl",   ADD_R7, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        step("t5_run",  NOP,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        idle(3);
        step("t5b_br0", NOP, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        step("t5b_br1", NOP, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        step("t5b_fl",  NOP, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        step("t5b_run", NOP, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t5c_br",  NOP, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        step("t5c_rst", NOP, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        step("t5c_post", NOP, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        // Self-dependent load stream: drives the small counter into saturation
        for (int k = 0; k < 40; k++) begin
`ifdef FORWARDING_EN
            step("t6_stream", LD_SELF, 1'b0, 1'b0, (k % 2) == 1, 1'b0,
                 ((k % 2) == 1 && k >= 3) ? 2'b10 : 2'b00, 2'b00);
`else
            step("t6_stream", LD_SELF, 1'b0, 1'b0, (k % 4) != 0, 1'b0, 2'b00, 2'b00);
`endif
        end
        idle(4);

        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
